write_back: RTL

MEM/WB pipeline register and write-back stage of the five-stage pipeline, directly downstream of the memory-access stage. Each cycle it captures the instruction leaving MEM, resolves conditional execution (ADC/ADZ/NDC/NDZ) against the architectural carry/zero flags it owns, and drives the register-file write port. It also sequences multi-beat LM writes across the 8-bit register mask. It supplies the MEM/WB IR, the squash flag and the write data that the memory stage's store-data forwarding consumes.

---
 rtl/write_back_if.sv | 39 +++
 rtl/write_back.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/write_back_if.sv
// write_back_if: MEM -> WB bus for the write_back stage.
//   Inputs to WB : in_valid, flush, IRfrompipe4, ALUOut, MemData, PCInc,
//                  carry_in, zero_in
//   Outputs of WB: IRfrompipe5, RegWrite, RegWriteAddr, RegWriteData,
//                  mem_wb_CCR_write, carry_flag, zero_flag, lm_last
// The master modport is the upstream (MEM) side; slave is write_back.
interface write_back_if;
    logic        in_valid;
    logic        flush;
    logic [15:0] IRfrompipe4;
    logic [15:0] ALUOut;
    logic [15:0] MemData;
    logic [15:0] PCInc;
    logic        carry_in;
    logic        zero_in;

    logic [15:0] IRfrompipe5;
    logic        RegWrite;
    logic [2:0]  RegWriteAddr;
    logic [15:0] RegWriteData;
    logic        mem_wb_CCR_write;
    logic        carry_flag;
    logic        zero_flag;
    logic        lm_last;

    modport master (
        output in_valid, flush, IRfrompipe4, ALUOut, MemData, PCInc,
               carry_in, zero_in,
        input  IRfrompipe5, RegWrite, RegWriteAddr, RegWriteData,
               mem_wb_CCR_write, carry_flag, zero_flag, lm_last
    );

    modport slave (
        input  in_valid, flush, IRfrompipe4, ALUOut, MemData, PCInc,
               carry_in, zero_in,
        output IRfrompipe5, RegWrite, RegWriteAddr, RegWriteData,
               mem_wb_CCR_write, carry_flag, zero_flag, lm_last
    );
endinterface

// File: rtl/write_back.sv
// write_back: MEM/WB pipeline register and write-back stage.
// Captures the instruction leaving MEM, resolves conditional ADD/NAND
// variants against the architectural C/Z flags held here, drives the
// register-file write port, and sequences multi-beat LM writes.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - write_back_if.slave (MEM-side inputs, WB outputs, lm_last)
module write_back (
    input  logic          clk,
    input  logic          reset,
    write_back_if.slave   bus
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;

    localparam logic [15:0] BUBBLE_IR = 16'hF000;

    typedef enum logic {LM_IDLE, LM_BUSY} lm_state_t;

    lm_state_t   state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] ir_q, ir_d;
    logic        reg_write_q, reg_write_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        ccr_q, ccr_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;

    logic [3:0]  opcode;
    logic [1:0]  cz;
    logic        cond_ok;
    logic [7:0]  lm_active;
    logic [7:0]  lm_rest;
    logic [2:0]  lm_idx;
    logic        lm_found;

    always_comb begin
        opcode = bus.IRfrompipe4[15:12];
        cz     = bus.IRfrompipe4[1:0];

        unique case (cz)
            2'b10:   cond_ok = carry_q;
            2'b01:   cond_ok = zero_q;
            default: cond_ok = 1'b1;
        endcase

        // A fresh LM takes its mask from the instruction; later beats
        // continue from whatever bits are still outstanding.
        lm_active = (state_q == LM_BUSY) ? rem_q : bus.IRfrompipe4[7:0];
        lm_idx    = '0;
        lm_found  = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (lm_active[i] && !lm_found) begin
                lm_idx   = 3'(i);
                lm_found = 1'b1;
            end
        end
        lm_rest = lm_found ? (lm_active & ~(8'(1) << lm_idx)) : '0;

        bus.lm_last = bus.in_valid && (opcode == OP_LM) && !reset
                      && (lm_rest == '0);
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        ir_d        = BUBBLE_IR;
        reg_write_d = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        ccr_d       = 1'b0;
        carry_d     = carry_q;
        zero_d      = zero_q;

        if (bus.flush) begin
            // Flush abandons any LM in progress; earlier beats already wrote.
            state_d = LM_IDLE;
            rem_d   = '0;
        end else if (bus.in_valid) begin
            ir_d = bus.IRfrompipe4;
            unique case (opcode)
                OP_ADD, OP_NDU: begin
                    if (cond_ok) begin
                        reg_write_d = 1'b1;
                        addr_d      = bus.IRfrompipe4[5:3];
                        data_d      = bus.ALUOut;
                        zero_d      = bus.zero_in;
                        if (opcode == OP_ADD) carry_d = bus.carry_in;
                    end else begin
                        ccr_d = 1'b1;
                    end
                end
                OP_ADI: begin
                    reg_write_d = 1'b1;
                    addr_d      = bus.IRfrompipe4[8:6];
                    data_d      = bus.ALUOut;
                    carry_d     = bus.carry_in;
                    zero_d      = bus.zero_in;
                end
                OP_LHI: begin
                    reg_write_d = 1'b1;
                    addr_d      = bus.IRfrompipe4[11:9];
                    data_d      = bus.ALUOut;
                end
                OP_LW: begin
                    reg_write_d = 1'b1;
                    addr_d      = bus.IRfrompipe4[11:9];
                    data_d      = bus.MemData;
                    zero_d      = (bus.MemData == '0);
                end
                OP_JAL, OP_JLR: begin
                    reg_write_d = 1'b1;
                    addr_d      = bus.IRfrompipe4[11:9];
                    data_d      = bus.PCInc;
                end
                OP_LM: begin
                    if (lm_found) begin
                        reg_write_d = 1'b1;
                        addr_d      = lm_idx;
                        data_d      = bus.MemData;
                    end
                    rem_d   = lm_rest;
                    state_d = (lm_rest != '0) ? LM_BUSY : LM_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LM_IDLE;
            rem_q       <= '0;
            ir_q        <= BUBBLE_IR;
            reg_write_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            ccr_q       <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            ir_q        <= ir_d;
            reg_write_q <= reg_write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ccr_q       <= ccr_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.IRfrompipe5      = ir_q;
    assign bus.RegWrite         = reg_write_q;
    assign bus.RegWriteAddr     = addr_q;
    assign bus.RegWriteData     = data_q;
    assign bus.mem_wb_CCR_write = ccr_q;
    assign bus.carry_flag       = carry_q;
    assign bus.zero_flag        = zero_q;
endmodule
